uart_rx_poller: RTL and testbench

Autonomous receive-side controller for the AXI4-lite UART Lite core. Sequences the AXI4-lite read channel: polls the status register, and whenever the RX-valid bit is set and buffer space exists, reads the RX FIFO register. Received bytes go into a local FIFO that the CPU core pops through a valid/ready interface. It replaces per-byte software-driven reads, so the core never stalls on an AXI round trip.

---
 rtl/uart_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/uart_rx_poller.sv | 141 ++++++++++++++
 tb/tb_uart_rx_poller.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART Lite AXI4-lite helpers: poller states,
// default register map and status register bit positions.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_GAP,
        ST_STAT_AR,
        ST_STAT_R,
        ST_DATA_AR,
        ST_DATA_R
    } rx_poll_state_e;

    localparam logic [3:0] UART_RX_ADDR   = 4'h0;
    localparam logic [3:0] UART_TX_ADDR   = 4'h4;
    localparam logic [3:0] UART_STAT_ADDR = 4'h8;
    localparam logic [3:0] UART_CTRL_ADDR = 4'hC;

    localparam int unsigned STAT_RX_VALID = 0;
    localparam int unsigned STAT_RX_FULL  = 1;
    localparam int unsigned STAT_TX_EMPTY = 2;
    localparam int unsigned STAT_TX_FULL  = 3;

    // Width of a down-counter able to hold the value gap (at least 1 bit).
    function automatic int unsigned gap_width(input int unsigned gap);
        return (gap < 2) ? 1 : $clog2(gap + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO; DEPTH must be a power of two (pointers wrap
// naturally). Push when full and pop when empty are ignored.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ;
    logic             do_push;
    logic             do_pop;

    assign full    = (occ == (AW+1)'(DEPTH));
    assign empty   = (occ == '0);
    assign count   = occ;
    assign dout    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   occ <= occ + (AW+1)'(1);
                2'b01:   occ <= occ - (AW+1)'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/uart_rx_poller.sv
// Polls the UART Lite status register over AXI4-lite and drains RX bytes into
// a local FIFO. Define UART_RX_POLLER_STATS_EN to enable the rx_count counter.
module uart_rx_poller
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned POLL_GAP  = 4,
    parameter logic [3:0]  STAT_ADDR = UART_STAT_ADDR,
    parameter logic [3:0]  RX_ADDR   = UART_RX_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [3:0]  uart_axi_araddr,
    output logic        uart_axi_arvalid,
    input  logic        uart_axi_arready,
    input  logic [31:0] uart_axi_rdata,
    input  logic [1:0]  uart_axi_rresp,
    input  logic        uart_axi_rvalid,
    output logic        uart_axi_rready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        err,
    output logic [15:0] rx_count
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned GW = gap_width(POLL_GAP);
    localparam logic [GW-1:0] GAP_LOAD = GW'(POLL_GAP);

    rx_poll_state_e state;
    rx_poll_state_e state_nxt;
    logic [GW-1:0]  gap_cnt;
    logic           gap_done;
    logic           push;
    logic           err_set;
    logic           fifo_full;
    logic           fifo_empty;
    logic [CW-1:0]  fifo_count;
    logic           unused_bits;

    // GAP always lasts at least one cycle, so a gap of 0 and 1 behave alike.
    assign gap_done = (gap_cnt <= GW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_GAP;
            gap_cnt <= GAP_LOAD;
        end else begin
            state <= state_nxt;
            if (state_nxt == ST_GAP && state != ST_GAP)
                gap_cnt <= GAP_LOAD;
            else if (state == ST_GAP && gap_cnt != '0)
                gap_cnt <= gap_cnt - GW'(1);
        end
    end

    always_comb begin
        state_nxt        = state;
        uart_axi_araddr  = STAT_ADDR;
        uart_axi_arvalid = 1'b0;
        uart_axi_rready  = 1'b0;
        push             = 1'b0;
        err_set          = 1'b0;
        case (state)
            ST_GAP: begin
                if (gap_done && en) state_nxt = ST_STAT_AR;
            end
            ST_STAT_AR: begin
                uart_axi_arvalid = 1'b1;
                if (uart_axi_arready) state_nxt = ST_STAT_R;
            end
            ST_STAT_R: begin
                uart_axi_rready = 1'b1;
                if (uart_axi_rvalid) begin
                    err_set = (uart_axi_rresp != 2'b00);
                    // Space is reserved here; only pops can happen before the push.
                    if (uart_axi_rresp == 2'b00 && uart_axi_rdata[STAT_RX_VALID] && !fifo_full)
                        state_nxt = ST_DATA_AR;
                    else
                        state_nxt = ST_GAP;
                end
            end
            ST_DATA_AR: begin
                uart_axi_araddr  = RX_ADDR;
                uart_axi_arvalid = 1'b1;
                if (uart_axi_arready) state_nxt = ST_DATA_R;
            end
            ST_DATA_R: begin
                uart_axi_araddr = RX_ADDR;
                uart_axi_rready = 1'b1;
                if (uart_axi_rvalid) begin
                    push      = (uart_axi_rresp == 2'b00);
                    err_set   = (uart_axi_rresp != 2'b00);
                    state_nxt = en ? ST_STAT_AR : ST_GAP;
                end
            end
            default: state_nxt = ST_GAP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          err <= 1'b0;
        else if (err_set) err <= 1'b1;
    end

    sync_fifo #(
        .WIDTH(8),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (uart_axi_rdata[7:0]),
        .pop   (rx_ready),
        .dout  (rx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign rx_valid    = !fifo_empty;
    assign unused_bits = ^{uart_axi_rdata[31:8], fifo_count};

`ifdef UART_RX_POLLER_STATS_EN
    logic [15:0] count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else if (push && count_q != 16'hFFFF)
            count_q <= count_q + 16'd1;
    end

    assign rx_count = count_q;
`else
    assign rx_count = '0;
`endif

endmodule

// File: tb/tb_uart_rx_poller.sv
// Scoreboard bench for uart_rx_poller: a reactive AXI4-lite slave model issues
// randomized responses, a separate monitor checks the consumer side.
module tb_uart_rx_poller;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned GAP    = 4;
    localparam logic [3:0]  STAT_A = 4'h8;
    localparam logic [3:0]  RX_A   = 4'h0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic [3:0]  araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata   = '0;
    logic [1:0]  rresp   = '0;
    logic        rvalid  = 1'b0;
    logic        rready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b0;
    logic        err;
    logic [15:0] rx_count;

    always #5 clk = ~clk;

    uart_rx_poller #(
        .DEPTH     (DEPTH),
        .POLL_GAP  (GAP),
        .STAT_ADDR (STAT_A),
        .RX_ADDR   (RX_A)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .en               (en),
        .uart_axi_araddr  (araddr),
        .uart_axi_arvalid (arvalid),
        .uart_axi_arready (arready),
        .uart_axi_rdata   (rdata),
        .uart_axi_rresp   (rresp),
        .uart_axi_rvalid  (rvalid),
        .uart_axi_rready  (rready),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .rx_ready         (rx_ready),
        .err              (err),
        .rx_count         (rx_count)
    );

    int unsigned total = 0;
    int unsigned bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: bytes accepted but not yet consumed, sticky error, push count.
    logic [7:0]  exp_q[$];
    logic [7:0]  data_list[$];
    bit          err_model = 0;
    int unsigned pushes_model = 0;
    bit          pend_v = 0, pend_push = 0, pend_err = 0;
    logic [7:0]  pend_byte = '0;

    // Stimulus knobs
    int          stat_mode = 0;      // 0 never valid, 1 always, 2 random
    int          ready_mode = 1;     // 0 never, 1 always, 2 random
    int unsigned max_ar_wait = 0, max_r_wait = 0;
    int          force_ar_wait = -1;
    int unsigned data_err_pct = 0, stat_err_pct = 0;
    bit          pop_once = 0;
    bit          check_period = 0;

    // Slave bookkeeping
    bit          ar_active = 0, r_pending = 0, last_stat_empty = 0;
    logic [3:0]  ar_addr0 = '0, r_addr = '0, exp_addr = STAT_A;
    int unsigned ar_wait = 0, r_wait = 0;
    int unsigned cyc = 0, last_ar_cyc = 0, ar_start_cyc = 0;
    int unsigned data_reads = 0, ar_starts = 0;

    function automatic logic [15:0] exp_count();
`ifdef UART_RX_POLLER_STATS_EN
        return (pushes_model > 32'hFFFF) ? 16'hFFFF : 16'(pushes_model);
`else
        return 16'h0;
`endif
    endfunction

    task automatic model_reset();
        exp_q.delete();
        pend_v = 0; err_model = 0; pushes_model = 0;
        ar_active = 0; r_pending = 0; last_stat_empty = 0;
        exp_addr = STAT_A; last_ar_cyc = 0;
    endtask

    // One cycle of slave + consumer behaviour, called just after a falling edge.
    task automatic step();
        logic [7:0] b;
        cyc++;
        if (pend_v) begin
            if (pend_push) begin
                exp_q.push_back(pend_byte);
                pushes_model++;
            end
            if (pend_err) err_model = 1;
            pend_v = 0;
        end
        arready = 1'b0;
        rvalid  = 1'b0;
        rresp   = 2'b00;
        rdata   = $urandom;
        check("rready_in_r_phase", rready, r_pending);
        if (r_pending) begin
            if (r_wait > 0) r_wait--;
            else begin
                rvalid = 1'b1;
                r_pending = 0;
                pend_v = 1; pend_push = 0; pend_err = 0;
                if (r_addr == STAT_A) begin
                    case (stat_mode)
                        0: rdata[0] = 1'b0;
                        1: rdata[0] = 1'b1;
                        default: rdata[0] = 1'($urandom_range(1));
                    endcase
                    if ($urandom_range(99) < stat_err_pct) rresp = 2'b10;
                    pend_err = (rresp != 2'b00);
                    exp_addr = (rresp == 2'b00 && rdata[0] && exp_q.size() < DEPTH) ? RX_A : STAT_A;
                    last_stat_empty = (exp_addr == STAT_A);
                end else begin
                    data_reads++;
                    b = (data_list.size() != 0) ? data_list.pop_front() : 8'($urandom);
                    rdata[7:0] = b;
                    if ($urandom_range(99) < data_err_pct) rresp = 2'b10;
                    pend_push = (rresp == 2'b00);
                    pend_err  = (rresp != 2'b00);
                    pend_byte = b;
                    exp_addr = STAT_A;
                    last_stat_empty = 0;
                end
            end
        end else if (arvalid) begin
            if (!ar_active) begin
                ar_active = 1;
                ar_addr0 = araddr;
                ar_start_cyc = cyc;
                ar_wait = (force_ar_wait >= 0) ? int'(force_ar_wait) : $urandom_range(max_ar_wait);
                ar_starts++;
                check("araddr", araddr, exp_addr);
                if (check_period && araddr == STAT_A && last_stat_empty && last_ar_cyc != 0)
                    check("poll_period", cyc - last_ar_cyc, GAP + 2);
                last_ar_cyc = cyc;
            end else begin
                check("araddr_stable", araddr, ar_addr0);
            end
            if (ar_wait > 0) ar_wait--;
            else begin
                arready = 1'b1;
                if (force_ar_wait >= 0)
                    check("ar_hold_cycles", cyc - ar_start_cyc + 1, force_ar_wait + 1);
                ar_active = 0;
                r_pending = 1;
                r_addr = araddr;
                r_wait = $urandom_range(max_r_wait);
            end
        end else if (ar_active) begin
            check("arvalid_held", arvalid, 1'b1);
            ar_active = 0;
        end
        case (ready_mode)
            0: rx_ready = 1'b0;
            1: rx_ready = 1'b1;
            default: rx_ready = 1'($urandom_range(1));
        endcase
        if (pop_once && rx_valid) begin
            rx_ready = 1'b1;
            pop_once = 0;
        end
    endtask

    task automatic run(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            step();
        end
    endtask

    task automatic wait_first_ar();
        bit seen = 0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (arvalid) begin
                seen = 1;
                check("first_ar_latency", k, GAP);
            end
            step();
        end
        if (!seen) check("first_ar_timeout", 0, 1);
    endtask

    // Monitor: pops the scoreboard whenever the DUT hands a byte to the consumer.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                check("rx_valid", rx_valid, exp_q.size() != 0);
                check("err", err, err_model);
                check("rx_count", rx_count, exp_count());
                if (rx_valid && rx_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rx_data", rx_data, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned base, starts;
        bit hit;
        #1;
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_rx_count", rx_count, 16'h0);
        check("rst_araddr", araddr, STAT_A);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        wait_first_ar();

        // No data pending: status-only polling at a fixed period.
        stat_mode = 0; check_period = 1;
        base = data_reads;
        run(60);
        check("no_data_reads", data_reads - base, 0);
        check_period = 0;

        // Two directed bytes with an always-ready consumer.
        data_list.push_back(8'h41);
        data_list.push_back(8'h42);
        stat_mode = 1; ready_mode = 1;
        base = data_reads;
        for (int i = 0; i < 100 && data_reads < base + 2; i++) run(1);
        stat_mode = 0;
        check("two_byte_reads", data_reads - base, 2);
        run(20);

        // Consumer stalled: the FIFO fills and further data reads stop.
        ready_mode = 0; stat_mode = 1;
        base = data_reads;
        run(80);
        check("fill_reads", data_reads - base, DEPTH);
        check("fill_level", exp_q.size(), DEPTH);
        pop_once = 1;
        run(60);
        check("refill_reads", data_reads - base, DEPTH + 1);
        check("refill_level", exp_q.size(), DEPTH);

        // Slow arready: request held for ten cycles.
        ready_mode = 1; stat_mode = 2; force_ar_wait = 10;
        run(60);
        force_ar_wait = -1;

        // Error responses on data reads: sticky err, nothing pushed, polling continues.
        stat_mode = 1; data_err_pct = 100;
        base = data_reads;
        run(30);
        check("err_sticky", err, 1'b1);
        data_err_pct = 0;
        run(30);
        check("poll_after_err", (data_reads - base) > 2, 1'b1);

        // Randomized traffic.
        stat_mode = 2; ready_mode = 2; max_ar_wait = 3; max_r_wait = 3;
        data_err_pct = 5; stat_err_pct = 5;
        run(2000);

        // Disabled: outstanding work drains, then no further requests.
        en = 1'b0;
        run(30);
        starts = ar_starts;
        run(30);
        check("en_low_no_requests", ar_starts - starts, 0);
        en = 1'b1;

        // Reset while a data read is outstanding with bytes buffered.
        ready_mode = 0; stat_mode = 1; data_err_pct = 0; stat_err_pct = 0;
        hit = 0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk);
            if (r_pending && r_addr == RX_A && rready && rx_valid) hit = 1;
            else step();
        end
        check("reached_data_r", hit, 1'b1);
        #1;
        rst = 1'b1;
        arready = 1'b0;
        rvalid = 1'b0;
        #1;
        check("async_arvalid", arvalid, 1'b0);
        check("async_rready", rready, 1'b0);
        check("async_rx_valid", rx_valid, 1'b0);
        check("async_err", err, 1'b0);
        check("async_rx_count", rx_count, 16'h0);
        check("async_araddr", araddr, STAT_A);
        model_reset();
        rx_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ready_mode = 2; stat_mode = 2;
        wait_first_ar();
        run(300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
